// File: rtl/ram512_ctrl_pkg.sv
// Shared constants and FSM state type for the 512x1 RAM arbiter.
package ram512_ctrl_pkg;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/ram512x1s_arbiter_rr_arb2.sv
// rr_arb2: two-input arbiter with a priority pointer; fixed or round-robin priority.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  // Pointer names the requester favoured on a tie; the winner just served loses the next tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= o_gnt[0];
    end else begin
      r_ptr <= r_ptr;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
      if (FIXED_PRIO || !r_ptr) begin
        o_gnt = 2'b01;
      end else begin
        o_gnt = 2'b10;
      end
    end else if (i_req0) begin
      o_gnt = 2'b01;
    end else if (i_req1) begin
      o_gnt = 2'b10;
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/ram512x1s_arbiter.sv
// ram512x1s_arbiter: shares one 512x1 single-port RAM between two requesters.
// Define CLEAR_SEQ_EN to build the clear sequencer (CLEAR state, 9-bit counter).
module ram512x1s_arbiter
  import ram512_ctrl_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter bit CLR_VAL    = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              REQ0_VLD,
  output logic              REQ0_RDY,
  input  logic              REQ0_WE,
  input  logic [ADDR_W-1:0] REQ0_A,
  input  logic              REQ0_D,
  input  logic              REQ1_VLD,
  output logic              REQ1_RDY,
  input  logic              REQ1_WE,
  input  logic [ADDR_W-1:0] REQ1_A,
  input  logic              REQ1_D,
  output logic              RSP0_VLD,
  output logic              RSP0_Q,
  output logic              RSP1_VLD,
  output logic              RSP1_Q,
  output logic              RAM_WE,
  output logic [ADDR_W-1:0] RAM_A,
  output logic              RAM_D,
  input  logic              RAM_O,
  output logic              BUSY
);

  state_e            w_state;
  logic [ADDR_W-1:0] w_cnt;
  logic              w_clr_blk;
  logic [1:0]        w_gnt;
  logic              w_acc;
  logic              r_rsp0_vld, r_rsp0_q, r_rsp1_vld, r_rsp1_q;

`ifdef CLEAR_SEQ_EN
  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A CLR pulse always (re)starts the sweep from address 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (CLR) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == ADDR_W'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (CLR) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_state   = r_state;
  assign w_cnt     = r_cnt;
  assign w_clr_blk = CLR;
`else
  logic w_unused_clr;
  assign w_unused_clr = CLR;
  assign w_state      = ST_RUN;
  assign w_cnt        = '0;
  assign w_clr_blk    = 1'b0;
`endif

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_req0   (REQ0_VLD),
    .i_req1   (REQ1_VLD),
    .i_accept (w_acc),
    .o_gnt    (w_gnt)
  );

  // Ready and RAM port drive; the RAM address defaults to requester 0 when idle.
  always_comb begin
    REQ0_RDY = 1'b0;
    REQ1_RDY = 1'b0;
    RAM_WE   = 1'b0;
    RAM_A    = REQ0_A;
    RAM_D    = REQ0_D;
    BUSY     = 1'b0;
    if (w_state == ST_CLEAR) begin
      RAM_WE = 1'b1;
      RAM_A  = w_cnt;
      RAM_D  = CLR_VAL;
      BUSY   = 1'b1;
    end else if (!w_clr_blk) begin
      REQ0_RDY = w_gnt[0];
      REQ1_RDY = w_gnt[1];
      if (w_gnt[1]) begin
        RAM_WE = REQ1_WE;
        RAM_A  = REQ1_A;
        RAM_D  = REQ1_D;
      end else if (w_gnt[0]) begin
        RAM_WE = REQ0_WE;
      end else begin
        RAM_WE = 1'b0;
      end
    end else begin
      RAM_WE = 1'b0;
    end
  end

  assign w_acc = REQ0_RDY | REQ1_RDY;

  // Capture the pre-access RAM bit at the accepting edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rsp0_vld <= 1'b0;
      r_rsp0_q   <= 1'b0;
      r_rsp1_vld <= 1'b0;
      r_rsp1_q   <= 1'b0;
    end else begin
      r_rsp0_vld <= REQ0_RDY;
      r_rsp1_vld <= REQ1_RDY;
      if (REQ0_RDY) begin
        r_rsp0_q <= RAM_O;
      end
      if (REQ1_RDY) begin
        r_rsp1_q <= RAM_O;
      end
    end
  end

  assign RSP0_VLD = r_rsp0_vld;
  assign RSP0_Q   = r_rsp0_q;
  assign RSP1_VLD = r_rsp1_vld;
  assign RSP1_Q   = r_rsp1_q;

endmodule

// File: tb/tb_ram512x1s_arbiter.sv
// Self-checking bench for ram512x1s_arbiter against a behavioural memory/arbitration model.
module tb_ram512x1s_arbiter;
  import ram512_ctrl_pkg::*;

`ifdef CLEAR_SEQ_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  localparam bit CLRV = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       r0_vld = 1'b0, r0_we = 1'b0, r0_d = 1'b0;
  logic       r1_vld = 1'b0, r1_we = 1'b0, r1_d = 1'b0;
  logic [8:0] r0_a = 9'd0, r1_a = 9'd0;
  logic       rdy0, rdy1, rv0, rq0, rv1, rq1, ram_we, ram_d, ram_o, busy;
  logic [8:0] ram_a;
  logic       fp_rdy0, fp_rdy1, fp_rv0, fp_rq0, fp_rv1, fp_rq1, fp_we, fp_d, fp_o, fp_busy;
  logic [8:0] fp_a;
  bit         ram_m  [DEPTH];
  bit         ram_fp [DEPTH];

  always #5 clk = ~clk;

  ram512x1s_arbiter #(.FIXED_PRIO(1'b0), .CLR_VAL(CLRV)) u_dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .REQ0_VLD(r0_vld), .REQ0_RDY(rdy0), .REQ0_WE(r0_we), .REQ0_A(r0_a), .REQ0_D(r0_d),
    .REQ1_VLD(r1_vld), .REQ1_RDY(rdy1), .REQ1_WE(r1_we), .REQ1_A(r1_a), .REQ1_D(r1_d),
    .RSP0_VLD(rv0), .RSP0_Q(rq0), .RSP1_VLD(rv1), .RSP1_Q(rq1),
    .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_D(ram_d), .RAM_O(ram_o), .BUSY(busy)
  );

  ram512x1s_arbiter #(.FIXED_PRIO(1'b1), .CLR_VAL(CLRV)) u_fp (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .REQ0_VLD(r0_vld), .REQ0_RDY(fp_rdy0), .REQ0_WE(r0_we), .REQ0_A(r0_a), .REQ0_D(r0_d),
    .REQ1_VLD(r1_vld), .REQ1_RDY(fp_rdy1), .REQ1_WE(r1_we), .REQ1_A(r1_a), .REQ1_D(r1_d),
    .RSP0_VLD(fp_rv0), .RSP0_Q(fp_rq0), .RSP1_VLD(fp_rv1), .RSP1_Q(fp_rq1),
    .RAM_WE(fp_we), .RAM_A(fp_a), .RAM_D(fp_d), .RAM_O(fp_o), .BUSY(fp_busy)
  );

  // Distributed RAM primitives: synchronous write, asynchronous read.
  always @(posedge clk) if (ram_we) ram_m[ram_a] <= ram_d;
  assign ram_o = ram_m[ram_a];
  always @(posedge clk) if (fp_we) ram_fp[fp_a] <= fp_d;
  assign fp_o = ram_fp[fp_a];

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit mem_m [DEPTH];
  int ptr_m, clr_left, win, e_cnt, cyc;
  bit pend_v0, pend_q0, pend_v1, pend_q1;
  bit e_rdy0, e_rdy1, e_busy, e_rv0, e_rq0, e_rv1, e_rq1, e_we;
  logic [8:0] e_a;
  logic o_rdy0, o_rdy1, o_busy, o_rv0, o_rq0, o_rv1, o_rq1, o_we, o_fp0, o_fp1;
  logic [8:0] o_a;

  task automatic model_reset();
    ptr_m = 0;
    pend_v0 = 1'b0; pend_q0 = 1'b0; pend_v1 = 1'b0; pend_q1 = 1'b0;
    clr_left = CLR_EN ? DEPTH : 0;
    if (CLR_EN) for (int i = 0; i < DEPTH; i++) mem_m[i] = CLRV;
  endtask

  // One clock: drive at posedge+1, observe at negedge, advance the model for the edge.
  task automatic step(input logic v0, input logic we0, input logic [8:0] a0, input logic d0,
                      input logic v1, input logic we1, input logic [8:0] a1, input logic d1,
                      input logic c);
    r0_vld = v0; r0_we = we0; r0_a = a0; r0_d = d0;
    r1_vld = v1; r1_we = we1; r1_a = a1; r1_d = d1;
    clr = c;
    e_rv0 = pend_v0; e_rq0 = pend_q0; e_rv1 = pend_v1; e_rq1 = pend_q1;
    e_busy = (clr_left > 0);
    e_cnt = DEPTH - clr_left;
    win = -1;
    if (!e_busy && !(c && CLR_EN)) begin
      if (v0 && v1) win = ptr_m;
      else if (v0) win = 0;
      else if (v1) win = 1;
    end
    e_rdy0 = (win == 0);
    e_rdy1 = (win == 1);
    e_we = e_busy ? 1'b1 : (win == 0) ? we0 : (win == 1) ? we1 : 1'b0;
    e_a  = e_busy ? 9'(e_cnt) : (win == 1) ? a1 : a0;
    @(negedge clk);
    o_rdy0 = rdy0; o_rdy1 = rdy1; o_busy = busy; o_we = ram_we; o_a = ram_a;
    o_rv0 = rv0; o_rq0 = rq0; o_rv1 = rv1; o_rq1 = rq1; o_fp0 = fp_rdy0; o_fp1 = fp_rdy1;
    pend_v0 = (win == 0);
    pend_v1 = (win == 1);
    if (win == 0) begin
      pend_q0 = mem_m[a0];
      if (we0) mem_m[a0] = d0;
      ptr_m = 1;
    end else if (win == 1) begin
      pend_q1 = mem_m[a1];
      if (we1) mem_m[a1] = d1;
      ptr_m = 0;
    end
    if (CLR_EN && c) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = CLRV;
    end else if (clr_left > 0) begin
      clr_left--;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rv0, rq0, rv1, rq1} !== 4'b0000) begin
      failures++; $display("FAIL reset_rsp got=%b required=0000", {rv0, rq0, rv1, rq1});
    end
    checks++;
    if (busy !== CLR_EN || ram_we !== CLR_EN) begin
      failures++; $display("FAIL reset_busy got busy=%b we=%b required=%b", busy, ram_we, CLR_EN);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_clear_sweep();
    for (int i = 0; i < 700 && clr_left > 0; i++) begin
      idle();
      checks++;
      if (o_busy !== 1'b1 || o_we !== 1'b1 || o_a !== e_a || {o_rdy0, o_rdy1} !== 2'b00) begin
        failures++;
        $display("FAIL clear_sweep cyc=%0d got busy=%b we=%b a=%h required busy=1 we=1 a=%h", cyc, o_busy, o_we, o_a, e_a);
      end
    end
    idle();
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL clear_end busy=%b required 0", o_busy); end
    step(1'b1, 1'b0, 9'h1FF, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    idle();
    checks++;
    if (o_rv0 !== 1'b1 || o_rq0 !== e_rq0) begin
      failures++; $display("FAIL clear_read_1ff got vld=%b q=%b required vld=1 q=%b", o_rv0, o_rq0, e_rq0);
    end
  endtask

  task automatic test_latency();
    step(1'b1, 1'b1, 9'h055, 1'b1, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    checks++;
    if (o_rdy0 !== 1'b1 || o_rv0 !== 1'b0 || o_we !== 1'b1 || o_a !== 9'h055) begin
      failures++; $display("FAIL lat_wr_accept got rdy=%b rv=%b we=%b a=%h required 1 0 1 055", o_rdy0, o_rv0, o_we, o_a);
    end
    step(1'b1, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    checks++;
    if (o_rv0 !== 1'b1 || o_rq0 !== 1'b0 || o_rdy0 !== 1'b1 || o_we !== 1'b0) begin
      failures++; $display("FAIL lat_wr_rsp got rv=%b q=%b rdy=%b we=%b required 1 0 1 0", o_rv0, o_rq0, o_rdy0, o_we);
    end
    idle();
    checks++;
    if (o_rv0 !== 1'b1 || o_rq0 !== 1'b1) begin
      failures++; $display("FAIL lat_rd_rsp got rv=%b q=%b required 1 1", o_rv0, o_rq0);
    end
    idle();
    checks++;
    if (o_rv0 !== 1'b0 || o_we !== 1'b0) begin
      failures++; $display("FAIL lat_pulse got rv=%b we=%b required 0 0", o_rv0, o_we);
    end
  endtask

  task automatic test_contention();
    step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 9'h001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 9'(16 + i), 1'b0, 1'b1, 1'b0, 9'(32 + i), 1'b0, 1'b0);
      checks++;
      if (o_rdy0 !== ((i % 2) == 0) || o_rdy1 !== ((i % 2) == 1)) begin
        failures++; $display("FAIL rr_grant i=%0d got=%b%b required=%b%b", i, o_rdy0, o_rdy1, (i % 2) == 0, (i % 2) == 1);
      end
      checks++;
      if (o_fp0 !== 1'b1 || o_fp1 !== 1'b0) begin
        failures++; $display("FAIL fixed_grant i=%0d got=%b%b required=10", i, o_fp0, o_fp1);
      end
      checks++;
      if (o_rv0 !== e_rv0 || o_rv1 !== e_rv1) begin
        failures++; $display("FAIL rr_rsp i=%0d got=%b%b required=%b%b", i, o_rv0, o_rv1, e_rv0, e_rv1);
      end
    end
    idle();
  endtask

  task automatic test_same_addr();
    step(1'b1, 1'b1, 9'h100, 1'b1, 1'b1, 1'b0, 9'h100, 1'b0, 1'b0);
    checks++;
    if ({o_rdy0, o_rdy1} !== 2'b10) begin failures++; $display("FAIL same_grant got=%b%b required=10", o_rdy0, o_rdy1); end
    step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 9'h100, 1'b0, 1'b0);
    checks++;
    if (o_rdy1 !== 1'b1 || o_rv0 !== 1'b1 || o_rq0 !== 1'b0) begin
      failures++; $display("FAIL same_rsp0 got rdy1=%b rv0=%b q0=%b required 1 1 0", o_rdy1, o_rv0, o_rq0);
    end
    idle();
    checks++;
    if (o_rv1 !== 1'b1 || o_rq1 !== 1'b1) begin
      failures++; $display("FAIL same_rsp1 got rv1=%b q1=%b required 1 1", o_rv1, o_rq1);
    end
  endtask

  task automatic test_clr_in_run();
    step(1'b1, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h0AA, 1'b1, 1'b1, 1'b0, 9'h100, 1'b0, 1'b1);
    checks++;
    if (o_rdy0 !== e_rdy0 || o_rdy1 !== e_rdy1 || o_rv0 !== 1'b1) begin
      failures++; $display("FAIL clr_cycle got rdy=%b%b rv0=%b required rdy=%b%b rv0=1", o_rdy0, o_rdy1, o_rv0, e_rdy0, e_rdy1);
    end
    idle();
    checks++;
    if (o_busy !== e_busy) begin failures++; $display("FAIL clr_busy got=%b required=%b", o_busy, e_busy); end
    test_clear_sweep();
    foreach (mem_m[i]) if (i == 'h055 || i == 'h100) begin
      step(1'b1, 1'b0, 9'(i), 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
      idle();
      checks++;
      if (o_rv0 !== 1'b1 || o_rq0 !== e_rq0) begin
        failures++; $display("FAIL clr_readback a=%h got rv=%b q=%b required rv=1 q=%b", i, o_rv0, o_rq0, e_rq0);
      end
    end
  endtask

`ifdef CLEAR_SEQ_EN
  task automatic test_reset_mid_clear();
    step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 1'b0, 9'h055, 1'b0, 1'b1);
    for (int i = 0; i < 'h0A0; i++) idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b1 || ram_a !== 9'd0 || {rv0, rq0, rv1, rq1} !== 4'b0000) begin
      failures++; $display("FAIL midclr_reset got busy=%b a=%h rsp=%b required 1 000 0000", busy, ram_a, {rv0, rq0, rv1, rq1});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    test_clear_sweep();
  endtask
`endif

  task automatic test_random();
    logic c, v0, v1;
    logic [8:0] a0, a1;
    for (int i = 0; i < 400; i++) begin
      c  = ($urandom_range(0, 199) == 0);
      v0 = $urandom_range(0, 1);
      v1 = $urandom_range(0, 1);
      a0 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
      step(v0, 1'($urandom_range(0, 1)), a0, 1'($urandom_range(0, 1)),
           v1, 1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), c);
      checks++;
      if ({o_rdy0, o_rdy1, o_busy} !== {e_rdy0, e_rdy1, e_busy}) begin
        failures++; $display("FAIL rnd_ctl cyc=%0d got rdy/busy=%b%b%b required=%b%b%b", cyc, o_rdy0, o_rdy1, o_busy, e_rdy0, e_rdy1, e_busy);
      end
      checks++;
      if (o_we !== e_we || ((e_busy || win >= 0) && o_a !== e_a)) begin
        failures++; $display("FAIL rnd_ram cyc=%0d got we=%b a=%h required we=%b a=%h", cyc, o_we, o_a, e_we, e_a);
      end
      checks++;
      if (o_rv0 !== e_rv0 || o_rv1 !== e_rv1 || (e_rv0 && o_rq0 !== e_rq0) || (e_rv1 && o_rq1 !== e_rq1)) begin
        failures++; $display("FAIL rnd_rsp cyc=%0d got v=%b%b q=%b%b required v=%b%b q=%b%b", cyc, o_rv0, o_rv1, o_rq0, o_rq1, e_rv0, e_rv1, e_rq0, e_rq1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0;
    test_reset();
    test_clear_sweep();
    test_latency();
    test_contention();
    test_same_addr();
    test_clr_in_run();
`ifdef CLEAR_SEQ_EN
    test_reset_mid_clear();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
